// File: rtl/sram_access_arbiter.sv
// Two-port round-robin arbiter that sequences one access at a time onto a bank
// of DW-bit words with per-word load enables and per-word output disables.
module sram_access_arbiter #(
    parameter int WORDS = 4,
    parameter int AW    = 2,
    parameter int DW    = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [DW-1:0]    a_wdata,
    output logic             a_ack,
    output logic [DW-1:0]    a_rdata,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [DW-1:0]    b_wdata,
    output logic             b_ack,
    output logic [DW-1:0]    b_rdata,
    output logic [DW-1:0]    mem_d,
    output logic [WORDS-1:0] mem_load_n,
    output logic [WORDS-1:0] mem_hiz,
    input  logic [DW-1:0]    mem_q,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state, state_nxt;
    logic            last_grant_b;
    logic            own_b;
    logic            lat_we;
    logic [AW-1:0]   lat_addr;

    logic            grant_vld, grant_b;
    logic            g_we;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_wdata;
    logic [DW-1:0]   rd_data;

    logic [DW-1:0]    mem_d_nxt;
    logic [WORDS-1:0] load_n_nxt, hiz_nxt;
    logic             a_ack_nxt, b_ack_nxt;
    logic [DW-1:0]    a_rdata_nxt, b_rdata_nxt;

    // One-hot word decode; addresses at or beyond WORDS select nothing.
    function automatic logic [WORDS-1:0] word_sel(input logic [AW-1:0] addr);
        logic [WORDS-1:0] sel;
        sel = '0;
        for (int i = 0; i < WORDS; i++)
            if (addr == i[AW-1:0]) sel[i] = 1'b1;
        return sel;
    endfunction

    assign g_we    = grant_b ? b_we    : a_we;
    assign g_addr  = grant_b ? b_addr  : a_addr;
    assign g_wdata = grant_b ? b_wdata : a_wdata;
    assign rd_data = (|word_sel(lat_addr)) ? mem_q : '0;
    assign busy    = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state        <= IDLE;
            last_grant_b <= 1'b1;
            own_b        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_vld) begin
                last_grant_b <= grant_b;
                own_b        <= grant_b;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (grant_vld) begin
            lat_we   <= g_we;
            lat_addr <= g_addr;
        end
    end

    // On a tie, the port that did not win last time gets the bank.
    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_b   = 1'b0;
        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    grant_vld = 1'b1;
                    grant_b   = b_req && (!a_req || !last_grant_b);
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; mem_d doubles as the latched write data.
    always_comb begin
        mem_d_nxt   = mem_d;
        load_n_nxt  = '1;
        hiz_nxt     = '1;
        a_ack_nxt   = 1'b0;
        b_ack_nxt   = 1'b0;
        a_rdata_nxt = a_rdata;
        b_rdata_nxt = b_rdata;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    if (g_we) begin
                        mem_d_nxt  = g_wdata;
                        load_n_nxt = ~word_sel(g_addr);
                    end else begin
                        hiz_nxt = ~word_sel(g_addr);
                    end
                end
            end
            ACCESS: begin
                a_ack_nxt = !own_b;
                b_ack_nxt = own_b;
                if (!lat_we) begin
                    if (own_b) b_rdata_nxt = rd_data;
                    else       a_rdata_nxt = rd_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            mem_d      <= '0;
            mem_load_n <= '1;
            mem_hiz    <= '1;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            mem_d      <= mem_d_nxt;
            mem_load_n <= load_n_nxt;
            mem_hiz    <= hiz_nxt;
            a_ack      <= a_ack_nxt;
            b_ack      <= b_ack_nxt;
            a_rdata    <= a_rdata_nxt;
            b_rdata    <= b_rdata_nxt;
        end
    end

endmodule
